// File: rtl/hamming_encode_engine.sv
// hamming_encode_engine
// Hamming(16,11) SECDED encoder that masters a byte-wide data memory.
// On an accepted start it reads NUM_MSG 11-bit messages (two bytes each,
// low byte first) from SRC_BASE. It encodes each message into a 16-bit
// codeword and writes the codeword, low byte first, to DST_BASE.
// Each message takes five states: read lo, read hi, encode, write lo, write hi.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   begin a run; only honoured in IDLE or DONE
//   mem_addr     out  byte address for the current read or write
//   mem_rd_data  in   read data, combinational from mem_addr
//   mem_we       out  write strobe, memory captures mem_wr_data at posedge
//   mem_wr_data  out  write data
//   busy         out  high while a run is in progress
//   done         out  high in DONE until the next accepted start
module hamming_encode_engine #(
  parameter int ADDR_W   = 8,
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_we,
  output logic [7:0]        mem_wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_ENC,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        lo_q;
  logic [2:0]        hi_q;
  logic [15:0]       cw_q;

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic              last_msg;

  // Upper bits of the message high byte carry no data.
  logic unused_hi_bits;
  assign unused_hi_bits = ^mem_rd_data[7:3];

  function automatic logic [15:0] encode(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  // Address arithmetic wraps modulo 2^ADDR_W.
  assign offset   = {idx[ADDR_W-2:0], 1'b0};
  assign src_ptr  = ADDR_W'(SRC_BASE) + offset;
  assign dst_ptr  = ADDR_W'(DST_BASE) + offset;
  assign last_msg = (idx == ADDR_W'(NUM_MSG - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx  <= '0;
      lo_q <= '0;
      hi_q <= '0;
      cw_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) idx <= '0;
        S_RD_LO:        lo_q <= mem_rd_data;
        S_RD_HI:        hi_q <= mem_rd_data[2:0];
        S_ENC:          cw_q <= encode({hi_q, lo_q});
        S_WR_HI:        if (!last_msg) idx <= idx + 1'b1;
        default:        ;
      endcase
    end
  end

  // Memory strobes are decoded from the state register so that an
  // asynchronous reset removes mem_we immediately.
  always_comb begin
    state_nxt   = state;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wr_data = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RD_LO;
      end
      S_RD_LO: begin
        busy      = 1'b1;
        mem_addr  = src_ptr;
        state_nxt = S_RD_HI;
      end
      S_RD_HI: begin
        busy      = 1'b1;
        mem_addr  = src_ptr + 1'b1;
        state_nxt = S_ENC;
      end
      S_ENC: begin
        busy      = 1'b1;
        state_nxt = S_WR_LO;
      end
      S_WR_LO: begin
        busy        = 1'b1;
        mem_addr    = dst_ptr;
        mem_we      = 1'b1;
        mem_wr_data = cw_q[7:0];
        state_nxt   = S_WR_HI;
      end
      S_WR_HI: begin
        busy        = 1'b1;
        mem_addr    = dst_ptr + 1'b1;
        mem_we      = 1'b1;
        mem_wr_data = cw_q[15:8];
        state_nxt   = last_msg ? S_DONE : S_RD_LO;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_RD_LO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
